lsu_ctrl: RTL and testbench
===========================

// Module: lsu_ctrl
// PURPOSE
//  Load/store initiator for the word-wide data memory (DM). Accepts byte, halfword and word
//  load/store requests from the datapath and drives the DM's addr/w_data/r_mem/w_mem port.
//  Sub-word stores run as a read-modify-write, because DM only writes whole 32-bit words.
//  Sits between the execute stage and DM; the DM side is the memory's only master.
// PARAMETERS
//  DM_WORDS  256  depth of DM in 32-bit words; byte addresses >= 4*DM_WORDS are out of range
// PORTS
//  clk           in   1   rising-edge clock; DM samples writes on posedge, reads on negedge
//  rst           in   1   reset, synchronous, active-high
//  req_valid     in   1   request present
//  req_ready     out  1   high only in IDLE; a request is accepted when req_valid & req_ready
//  req_we        in   1   1=store, 0=load
//  req_size      in   2   00 byte, 01 half, 10 word; 11 is illegal and reported as an error
//  req_unsigned  in   1   loads: 1=zero-extend, 0=sign-extend
//  req_addr      in   32  byte address, little-endian
//  req_wdata     in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//  resp_valid    out  1   one-cycle pulse ending each accepted request
//  resp_rdata    out  32  extended load data; 0 for stores and errors
//  resp_err      out  1   valid with resp_valid: misaligned, out-of-range or illegal size
//  dm_addr       out  32  word-aligned byte address {addr[31:2],2'b00}; 0 in IDLE
//  dm_w_data     out  32  write data to DM
//  dm_r_data     in   32  read data from DM; stable by the posedge following an r_mem cycle
//  r_mem         out  1   DM read strobe
//  w_mem         out  1   DM write strobe
// BEHAVIOUR
//  - FSM states: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP. Moore outputs decode the state register.
//  - Request fields are latched on acceptance; inputs are ignored outside IDLE.
//  - Decode at acceptance:
//    - err if size==11, half with addr[0]=1, word with addr[1:0]!=0, or addr>=4*DM_WORDS.
//    - err -> RESP with resp_err=1 and no DM access.
//    - load -> LOAD; word store -> STORE; byte/half store -> RMW_RD.
//  - LOAD: r_mem=1. Capture dm_r_data at posedge, extract lane (byte k = bits[8k+7:8k],
//    half at addr[1] = bits[16*addr[1]+15:16*addr[1]]), extend, -> RESP.
//  - STORE: w_mem=1, dm_w_data=wdata -> RESP.
//  - RMW_RD: r_mem=1, capture word -> RMW_WR. RMW_WR: w_mem=1, dm_w_data = captured word with
//    the addressed byte/half replaced and other lanes unchanged -> RESP.
//  - RESP: resp_valid=1 for exactly one cycle -> IDLE.
//  - Latency (acceptance edge to resp_valid high):
//    - load and word store: 2 cycles
//    - sub-word store: 3 cycles
//    - error: 1 cycle
//    - next request can be accepted the cycle after RESP.
//  - r_mem and w_mem are never high together. Both are 0 in IDLE, RESP and error paths.
//  - Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, dm_addr=0,
//    dm_w_data=0, r_mem=0, w_mem=0.
//  - Reset mid-operation:
//    - the FSM returns to IDLE at that edge and no response is issued.
//    - DM has no reset, so a write whose w_mem cycle coincides with the rst edge commits.
//    - an aborted RMW_RD writes nothing.
//  - resp_rdata holds its value until the next RESP; it is only meaningful while resp_valid=1.
// STRUCTURE
//  - lsu_pkg: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD) and the state enum.
//  - Sub-module lsu_lane_align (combinational): load extract/extend and store lane merge.
//  - lsu_ctrl holds the FSM, request latches and error decode.
// TESTING
//  - Bench model: DM behavioural model with negedge read and posedge write, preloaded with
//    mem[1]=32'h8899AABB.
//  - Word load addr=4 -> r_mem for 1 cycle, dm_addr=4; resp_rdata=8899AABB, resp_valid 2 cycles after accept.
//  - Byte load addr=7, signed -> FFFFFF88; unsigned -> 00000088.
//  - Half load addr=6, signed -> FFFF8899.
//  - Byte store addr=5, wdata=0x12 -> RMW: r_mem cycle then w_mem cycle with
//    dm_w_data=8899 12BB (8899AA→12 lane1 = 889912BB); resp 3 cycles after accept.
//  - Half store addr=5 -> resp_err=1 with no r_mem/w_mem. Word load addr=1024 (DM_WORDS=256)
//    -> resp_err=1, resp_rdata=0.
//  - rst asserted during RMW_RD of byte store -> no w_mem, no resp_valid, req_ready=1 next cycle,
//    mem[1] unchanged.
//  - Back-to-back: word store 0xDEADBEEF to addr 8, then word load addr 8 in the cycle after RESP
//    -> returns DEADBEEF.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and the
// request error decode used at acceptance time.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STORE  = 3'd2,
    ST_RMW_RD = 3'd3,
    ST_RMW_WR = 3'd4,
    ST_RESP   = 3'd5
  } lsu_state_e;

  // A request is rejected for an illegal size, a misaligned half/word, or an
  // address beyond the end of DM (limit is the DM size in bytes).
  function automatic logic req_is_err(input logic [1:0]  size,
                                      input logic [31:0] addr,
                                      input logic [31:0] limit);
    logic bad;
    bad = 1'b0;
    if (size == SZ_ILL)                             bad = 1'b1;
    if ((size == SZ_HALF) && addr[0])               bad = 1'b1;
    if ((size == SZ_WORD) && (addr[1:0] != 2'b00))  bad = 1'b1;
    if (addr >= limit)                              bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: picks and extends the addressed byte/half of a
// DM word for loads, and merges store data into a DM word for sub-word writes.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] mem_word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Load path: shift the addressed byte down, choose the half by addr[1], then extend.
  always_comb begin
    shifted   = mem_word >> {addr_lo, 3'b000};
    byte_sel  = shifted[7:0];
    half_sel  = addr_lo[1] ? mem_word[31:16] : mem_word[15:0];
    load_data = 32'h0;
    case (size)
      SZ_BYTE: load_data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
      SZ_WORD: load_data = mem_word;
      default: load_data = 32'h0;
    endcase
  end

  // Store path: each byte lane either takes its slice of the store data or keeps the old byte.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic       lane_en;
    logic [7:0] lane_src;

    // Lane gi is written when the access covers it; halves use wdata bytes 0/1 by lane parity.
    always_comb begin
      lane_en  = 1'b0;
      lane_src = wdata[8*gi +: 8];
      case (size)
        SZ_BYTE: begin
          lane_en  = (addr_lo == 2'(gi));
          lane_src = wdata[7:0];
        end
        SZ_HALF: begin
          lane_en  = (addr_lo[1] == 1'(gi / 2));
          lane_src = wdata[8*(gi % 2) +: 8];
        end
        SZ_WORD: lane_en = 1'b1;
        default: lane_en = 1'b0;
      endcase
    end

    assign merged_word[8*gi +: 8] = lane_en ? lane_src : mem_word[8*gi +: 8];
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller for the word-wide data memory. Latches one request at
// a time, rejects bad ones without touching DM, and turns sub-word stores into
// a read-modify-write. All outputs are registered and follow the next state.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned DM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_w_data,
  input  logic [31:0] dm_r_data,
  output logic        r_mem,
  output logic        w_mem
);

  localparam logic [31:0] DM_BYTES = 32'(DM_WORDS * 4);

  lsu_state_e  state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] dm_addr_q, dm_addr_d;
  logic [31:0] dm_w_data_q, dm_w_data_d;
  logic        r_mem_q, r_mem_d;
  logic        w_mem_q, w_mem_d;

  logic [31:0] load_data;
  logic [31:0] merged_word;
  logic        req_err;

  // Lane logic always works on the latched request and the live DM read bus.
  lsu_lane_align u_align (
    .mem_word    (dm_r_data),
    .addr_lo     (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  assign req_err = req_is_err(req_size, req_addr, DM_BYTES);

  // Next state, request latches and registered outputs derived from the next state.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    unsigned_d   = unsigned_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = 1'b0;
    resp_valid_d = 1'b0;
    req_ready_d  = 1'b0;
    r_mem_d      = 1'b0;
    w_mem_d      = 1'b0;
    dm_addr_d    = 32'h0;
    dm_w_data_d  = 32'h0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d       = req_we;
          size_d     = req_size;
          unsigned_d = req_unsigned;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          if (req_err) begin
            state_d      = ST_RESP;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'h0;
          end else if (!req_we) begin
            state_d = ST_LOAD;
          end else if (req_size == SZ_WORD) begin
            state_d = ST_STORE;
          end else begin
            state_d = ST_RMW_RD;
          end
        end
      end
      ST_LOAD: begin
        resp_rdata_d = load_data;
        state_d      = ST_RESP;
      end
      ST_STORE: begin
        resp_rdata_d = 32'h0;
        state_d      = ST_RESP;
      end
      ST_RMW_RD: begin
        state_d = ST_RMW_WR;
      end
      ST_RMW_WR: begin
        resp_rdata_d = 32'h0;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Output decode for the state being entered; the merged word is formed from
    // the read data captured at the end of RMW_RD.
    case (state_d)
      ST_IDLE:   req_ready_d = 1'b1;
      ST_LOAD: begin
        r_mem_d   = 1'b1;
        dm_addr_d = {addr_d[31:2], 2'b00};
      end
      ST_STORE: begin
        w_mem_d     = 1'b1;
        dm_addr_d   = {addr_d[31:2], 2'b00};
        dm_w_data_d = wdata_d;
      end
      ST_RMW_RD: begin
        r_mem_d   = 1'b1;
        dm_addr_d = {addr_d[31:2], 2'b00};
      end
      ST_RMW_WR: begin
        w_mem_d     = 1'b1;
        dm_addr_d   = {addr_d[31:2], 2'b00};
        dm_w_data_d = merged_word;
      end
      ST_RESP:   resp_valid_d = 1'b1;
      default:   req_ready_d = 1'b0;
    endcase
  end

  // State, request latches and output registers; reset drops any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      size_q       <= SZ_BYTE;
      unsigned_q   <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
      dm_addr_q    <= 32'h0;
      dm_w_data_q  <= 32'h0;
      r_mem_q      <= 1'b0;
      w_mem_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      size_q       <= size_d;
      unsigned_q   <= unsigned_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      dm_addr_q    <= dm_addr_d;
      dm_w_data_q  <= dm_w_data_d;
      r_mem_q      <= r_mem_d;
      w_mem_q      <= w_mem_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign dm_addr    = dm_addr_q;
  assign dm_w_data  = dm_w_data_q;
  assign r_mem      = r_mem_q;
  assign w_mem      = w_mem_q;

  // The store data register is only needed by STORE and the merge; we_q is kept
  // for visibility of the latched request in debug.
  logic unused_we;
  assign unused_we = we_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: a driver issues directed requests and queues
// the hand-computed response; a negedge monitor pops and compares each response
// together with the DM strobes it observed for that transaction.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] dm_addr;
  logic [31:0] dm_w_data;
  logic [31:0] dm_r_data = 32'h0;
  logic        r_mem;
  logic        w_mem;

  lsu_ctrl #(.DM_WORDS(256)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .dm_addr(dm_addr), .dm_w_data(dm_w_data),
    .dm_r_data(dm_r_data), .r_mem(r_mem), .w_mem(w_mem)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // Behavioural DM: read on negedge, write on posedge, no reset.
  logic [31:0] mem [0:255];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[1] = 32'h8899AABB;
  end
  always @(negedge clk) if (r_mem) dm_r_data <= mem[dm_addr[9:2]];
  always @(posedge clk) if (w_mem) mem[dm_addr[9:2]] <= dm_w_data;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          rc;
    int          wc;
    logic [31:0] wdata;
    logic [31:0] addr;
    int          acc;
  } exp_t;

  exp_t sb[$];

  // Monitor: accumulate strobes for the transaction in flight, compare on resp_valid.
  int          mon_rc = 0;
  int          mon_wc = 0;
  logic        mon_overlap = 1'b0;
  logic [31:0] mon_wd = 32'h0;
  logic [31:0] mon_addr = 32'h0;

  always @(negedge clk) begin
    if (rst) begin
      mon_rc = 0; mon_wc = 0; mon_overlap = 1'b0;
    end else begin
      if (r_mem && w_mem) mon_overlap = 1'b1;
      if (r_mem) mon_rc++;
      if (w_mem) begin mon_wc++; mon_wd = dm_w_data; end
      if (r_mem || w_mem) mon_addr = dm_addr;
      if (resp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_resp", {31'h0, resp_valid}, 32'h0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          $display("TXN %s rdata=%h err=%0d lat=%0d r_mem=%0d w_mem=%0d",
                   e.name, resp_rdata, resp_err, cycle - e.acc + 1, mon_rc, mon_wc);
          chk({e.name, "_rdata"}, resp_rdata, e.rdata);
          chk({e.name, "_err"}, {31'h0, resp_err}, {31'h0, e.err});
          chk({e.name, "_lat"}, 32'(cycle - e.acc + 1), 32'(e.lat));
          chk({e.name, "_rcnt"}, 32'(mon_rc), 32'(e.rc));
          chk({e.name, "_wcnt"}, 32'(mon_wc), 32'(e.wc));
          chk({e.name, "_overlap"}, {31'h0, mon_overlap}, 32'h0);
          if (e.wc > 0) chk({e.name, "_wdata"}, mon_wd, e.wdata);
          if (e.rc + e.wc > 0) chk({e.name, "_dmaddr"}, mon_addr, e.addr);
        end
        mon_rc = 0; mon_wc = 0; mon_overlap = 1'b0;
      end
    end
  end

  // Driver: wait (bounded) for ready, present one request for one edge, queue expectation.
  task automatic issue(input string name, input bit we, input bit [1:0] sz, input bit uns,
                       input bit [31:0] addr, input bit [31:0] wd,
                       input bit [31:0] e_rdata, input bit e_err, input int e_lat,
                       input int e_rc, input int e_wc, input bit [31:0] e_wdata,
                       output int acc);
    exp_t e;
    int n;
    n = 0;
    acc = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk({name, "_ready_timeout"}, {31'h0, req_ready}, 32'h1);
      return;
    end
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    acc = cycle;
    e.name = name; e.rdata = e_rdata; e.err = e_err; e.lat = e_lat;
    e.rc = e_rc; e.wc = e_wc; e.wdata = e_wdata; e.addr = {addr[31:2], 2'b00};
    e.acc = acc;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(sb.size()), 32'h0);
  endtask

  int a0, a1;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
    chk("rst_dm_addr", dm_addr, 32'h0);
    chk("rst_dm_w_data", dm_w_data, 32'h0);
    chk("rst_strobes", {30'h0, r_mem, w_mem}, 32'h0);
    rst = 1'b0;

    //     name          we  size     uns  addr   wdata        rdata         err lat rc wc wdata
    issue("ld_w4",       0, SZ_WORD, 0, 32'd4,  32'h0,       32'h8899AABB, 0, 2, 1, 0, 32'h0, a0);
    issue("ld_b7_s",     0, SZ_BYTE, 0, 32'd7,  32'h0,       32'hFFFFFF88, 0, 2, 1, 0, 32'h0, a0);
    issue("ld_b7_u",     0, SZ_BYTE, 1, 32'd7,  32'h0,       32'h00000088, 0, 2, 1, 0, 32'h0, a0);
    issue("ld_h6_s",     0, SZ_HALF, 0, 32'd6,  32'h0,       32'hFFFF8899, 0, 2, 1, 0, 32'h0, a0);
    issue("st_b5",       1, SZ_BYTE, 0, 32'd5,  32'h12,      32'h0,        0, 3, 1, 1, 32'h889912BB, a0);
    issue("ld_b5_u",     0, SZ_BYTE, 1, 32'd5,  32'h0,       32'h00000012, 0, 2, 1, 0, 32'h0, a0);
    issue("st_h5_mis",   1, SZ_HALF, 0, 32'd5,  32'h1234,    32'h0,        1, 1, 0, 0, 32'h0, a0);
    issue("ld_w1024",    0, SZ_WORD, 0, 32'd1024, 32'h0,     32'h0,        1, 1, 0, 0, 32'h0, a0);
    issue("ld_ill_size", 0, SZ_ILL,  0, 32'd0,  32'h0,       32'h0,        1, 1, 0, 0, 32'h0, a0);
    issue("ld_w2_mis",   0, SZ_WORD, 0, 32'd2,  32'h0,       32'h0,        1, 1, 0, 0, 32'h0, a0);
    issue("st_h6",       1, SZ_HALF, 0, 32'd6,  32'h0000CAFE, 32'h0,       0, 3, 1, 1, 32'hCAFE12BB, a0);
    issue("st_b1023",    1, SZ_BYTE, 0, 32'd1023, 32'h77,    32'h0,        0, 3, 1, 1, 32'h77000000, a0);
    issue("ld_w1020",    0, SZ_WORD, 0, 32'd1020, 32'h0,     32'h77000000, 0, 2, 1, 0, 32'h0, a0);
    drain();

    // Reset during RMW_RD of a byte store: no write, no response, ready next cycle.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_BYTE; req_unsigned = 1'b0;
    req_addr = 32'd5; req_wdata = 32'h55;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_req_ready", {31'h0, req_ready}, 32'h1);
    chk("abort_w_mem", {31'h0, w_mem}, 32'h0);
    chk("abort_resp_valid", {31'h0, resp_valid}, 32'h0);
    repeat (4) @(negedge clk);
    chk("abort_mem1", mem[1], 32'hCAFE12BB);
    issue("ld_w4_post",  0, SZ_WORD, 0, 32'd4,  32'h0,       32'hCAFE12BB, 0, 2, 1, 0, 32'h0, a0);

    // Back-to-back: store then load accepted the cycle after RESP.
    issue("st_w8",       1, SZ_WORD, 0, 32'd8,  32'hDEADBEEF, 32'h0,       0, 2, 0, 1, 32'hDEADBEEF, a0);
    issue("ld_w8",       0, SZ_WORD, 0, 32'd8,  32'h0,       32'hDEADBEEF, 0, 2, 1, 0, 32'h0, a1);
    chk("b2b_accept_gap", 32'(a1 - a0), 32'd3);
    drain();

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
